// File: rtl/lib_len_to_keep.sv
// Frame beat generator: turns a byte length into per-beat keep masks with
// first/last flags and a beat index, one registered token per bus beat.

module lib_bin_to_vld #(
  parameter int W = 8
) (
  input  logic [$clog2(W)-1:0] bin,
  output logic [W-1:0]         vld
);

  localparam int BW = $clog2(W);

  always_comb begin
    vld = '0;
    for (int i = 0; i < W; i++) begin
      vld[i] = (BW'(i) <= bin);
    end
  end

endmodule

module lib_len_to_keep #(
  parameter int BYTES_PER_BEAT = 8,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          len_vld,
  output logic                                          len_rdy,
  input  logic [LEN_WIDTH-1:0]                          len,
  output logic                                          out_vld,
  input  logic                                          out_rdy,
  output logic [BYTES_PER_BEAT-1:0]                     out_keep,
  output logic                                          out_first,
  output logic                                          out_last,
  output logic [LEN_WIDTH-$clog2(BYTES_PER_BEAT)-1:0]   out_cnt,
  output logic                                          busy,
  output logic                                          zero_len_err
);

  localparam int LOG2B = $clog2(BYTES_PER_BEAT);
  localparam int CNT_W = LEN_WIDTH - LOG2B;
  localparam int REM_W = CNT_W + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state, state_nxt;
  logic [REM_W-1:0]          beats_rem_p1, beats_rem_nxt;
  logic [LOG2B-1:0]          last_bin_p1, last_bin_nxt;
  logic                      vld_nxt, first_nxt, last_nxt, zerr_nxt;
  logic [BYTES_PER_BEAT-1:0] keep_nxt, keep_last;
  logic [CNT_W-1:0]          cnt_nxt;

  logic                      len_acc, len_nz, start, beat_take, last_take;
  logic [LEN_WIDTH:0]        len_sum;
  logic [REM_W-1:0]          beats_new;
  logic [LOG2B-1:0]          bin_new, keep_bin;

  assign beat_take = out_vld & out_rdy;
  assign last_take = beat_take & out_last;
  assign len_rdy   = (state == IDLE) | last_take;
  assign len_acc   = len_vld & len_rdy;
  assign len_nz    = |len;
  assign start     = len_acc & len_nz;
  assign busy      = (state == RUN);

  // Beat count rounds up; the extra MSB holds the full 2^CNT_W case.
  assign len_sum   = {1'b0, len} + (LEN_WIDTH+1)'(BYTES_PER_BEAT - 1);
  assign beats_new = len_sum[LEN_WIDTH:LOG2B];
  assign bin_new   = len[LOG2B-1:0] - LOG2B'(1);

  // One mask decoder serves both a fresh single-beat frame and the tail beat.
  assign keep_bin  = start ? bin_new : last_bin_p1;

  lib_bin_to_vld #(.W(BYTES_PER_BEAT)) u_bin_to_vld (
    .bin (keep_bin),
    .vld (keep_last)
  );

  always_comb begin
    state_nxt     = state;
    vld_nxt       = out_vld;
    keep_nxt      = out_keep;
    first_nxt     = out_first;
    last_nxt      = out_last;
    cnt_nxt       = out_cnt;
    beats_rem_nxt = beats_rem_p1;
    last_bin_nxt  = last_bin_p1;
    zerr_nxt      = len_acc & ~len_nz;

    if (start) begin
      state_nxt     = RUN;
      vld_nxt       = 1'b1;
      first_nxt     = 1'b1;
      cnt_nxt       = '0;
      beats_rem_nxt = beats_new;
      last_bin_nxt  = bin_new;
      last_nxt      = (beats_new == REM_W'(1));
      keep_nxt      = (beats_new == REM_W'(1)) ? keep_last : '1;
    end else if (state == RUN && beat_take) begin
      if (out_last) begin
        state_nxt     = IDLE;
        vld_nxt       = 1'b0;
        keep_nxt      = '0;
        first_nxt     = 1'b0;
        last_nxt      = 1'b0;
        cnt_nxt       = '0;
        beats_rem_nxt = '0;
      end else begin
        beats_rem_nxt = beats_rem_p1 - REM_W'(1);
        cnt_nxt       = out_cnt + CNT_W'(1);
        first_nxt     = 1'b0;
        last_nxt      = (beats_rem_p1 == REM_W'(2));
        keep_nxt      = (beats_rem_p1 == REM_W'(2)) ? keep_last : '1;
      end
    end
  end

  // Output stage: registered token, held while the consumer stalls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      out_vld      <= 1'b0;
      out_keep     <= '0;
      out_first    <= 1'b0;
      out_last     <= 1'b0;
      out_cnt      <= '0;
      beats_rem_p1 <= '0;
      last_bin_p1  <= '0;
      zero_len_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      out_vld      <= vld_nxt;
      out_keep     <= keep_nxt;
      out_first    <= first_nxt;
      out_last     <= last_nxt;
      out_cnt      <= cnt_nxt;
      beats_rem_p1 <= beats_rem_nxt;
      last_bin_p1  <= last_bin_nxt;
      zero_len_err <= zerr_nxt;
    end
  end

endmodule

// File: tb/tb_lib_len_to_keep.sv
// Scoreboard bench for lib_len_to_keep: accepted lengths expand into expected
// beats in a queue; a monitor compares every presented token against it.

module tb_lib_len_to_keep;

  localparam int BPB   = 8;
  localparam int LW    = 16;
  localparam int CNT_W = LW - 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             len_vld;
  logic             len_rdy;
  logic [LW-1:0]    len;
  logic             out_vld;
  logic             out_rdy;
  logic [BPB-1:0]   out_keep;
  logic             out_first;
  logic             out_last;
  logic [CNT_W-1:0] out_cnt;
  logic             busy;
  logic             zero_len_err;

  lib_len_to_keep #(.BYTES_PER_BEAT(BPB), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .len_vld      (len_vld),
    .len_rdy      (len_rdy),
    .len          (len),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_keep     (out_keep),
    .out_first    (out_first),
    .out_last     (out_last),
    .out_cnt      (out_cnt),
    .busy         (busy),
    .zero_len_err (zero_len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int keep;
    bit first;
    bit last;
    int cnt;
  } beat_t;

  beat_t q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    zpend    = 1'b0;
  int    rdy_mode = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // A frame of L bytes is ceil(L/8) beats; each beat carries min(8, bytes left).
  task automatic push_frame(input int L);
    int n;
    n = (L + BPB - 1) / BPB;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      int    by;
      by = L - BPB * i;
      if (by > BPB) by = BPB;
      b.keep  = (1 << by) - 1;
      b.first = (i == 0);
      b.last  = (i == n - 1);
      b.cnt   = i;
      q.push_back(b);
    end
  endtask

  // Monitor: all checking happens here, at the falling edge or just after reset assertion.
  initial begin
    forever begin
      @(negedge clk or negedge rstn);
      if (!rstn) begin
        #1;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_keep", out_keep, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_zero_len_err", zero_len_err, 0);
        chk("rst_len_rdy", len_rdy, 1);
        q.delete();
        zpend = 1'b0;
      end else begin
        chk("out_vld", out_vld, q.size() != 0);
        chk("busy", busy, q.size() != 0);
        chk("zero_len_err", zero_len_err, zpend);
        chk("len_rdy", len_rdy, (q.size() == 0) || (out_rdy && q[0].last));
        if (out_vld && q.size() != 0) begin
          chk("out_keep", out_keep, q[0].keep);
          chk("out_first", out_first, q[0].first);
          chk("out_last", out_last, q[0].last);
          chk("out_cnt", out_cnt, q[0].cnt);
          if (out_rdy) void'(q.pop_front());
        end
        zpend = len_vld && len_rdy && (len == 0);
        if (len_vld && len_rdy && len != 0) push_frame(int'(len));
      end
    end
  end

  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom % 2);
    end
  end

  // Present a length and hold it until the falling-edge sample shows it accepted.
  task automatic issue(input int L);
    int n;
    len_vld = 1'b1;
    len     = L[LW-1:0];
    n       = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 20000) begin
        $display("FAIL issue_timeout: got no len_rdy expected acceptance of len=%0d", L);
        $fatal(1, "request never accepted");
      end
    end while (!len_rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    len_vld = 1'b0;
    len     = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 20000) begin
        $display("FAIL drain_timeout: got out_vld=%0d expected 0", out_vld);
        $fatal(1, "frame never drained");
      end
    end while (out_vld);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int L;
    rstn    = 1'b0;
    len_vld = 1'b0;
    len     = '0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    issue(1); issue(8); idle(); drain();
    issue(20); idle(); drain();

    rdy_mode = 1;
    issue(20); idle(); drain();
    rdy_mode = 0;

    issue(9); issue(3); idle(); drain();
    issue(0); idle(); repeat (2) @(posedge clk); #1;
    issue(65535); idle(); drain();

    issue(40); idle();
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        $display("FAIL beat1_timeout: got cnt=%0d expected 1", out_cnt);
        $fatal(1, "beat 1 never seen");
      end
    end while (!(out_vld && out_cnt == 1));
    #1;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    issue(5); idle(); drain();

    rdy_mode = 1;
    for (int k = 0; k < 150; k++) begin
      case ($urandom % 8)
        0:       L = 0;
        1:       L = $urandom_range(1, 8);
        2:       L = 8 * $urandom_range(1, 6);
        default: L = $urandom_range(1, 64);
      endcase
      issue(L);
      if ($urandom % 3 == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    idle();
    drain();
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
